// File: rtl/uart_pkg.sv
// Shared types and constants for the oversampling UART receiver.
package uart_pkg;

    typedef enum logic [2:0] {
        S_IDLE,
        S_START,
        S_DATA,
        S_PARITY,
        S_STOP,
        S_BREAK
    } rx_state_t;

    localparam logic [1:0] PAR_EVEN   = 2'b00;
    localparam logic [1:0] PAR_ODD    = 2'b01;
    localparam logic [1:0] PAR_STICK0 = 2'b10;
    localparam logic [1:0] PAR_STICK1 = 2'b11;

    localparam int DATA_BITS_OFFSET = 5;
    localparam int BITS_PER_CHAR    = 10;

    // Character width from the 3-bit config field, saturated to the widest build.
    function automatic logic [3:0] eff_data_bits(input logic [2:0] cfg_bits, input int max_bits);
        int n;
        n = int'(cfg_bits) + DATA_BITS_OFFSET;
        if (n > max_bits) n = max_bits;
        return 4'(n);
    endfunction

    function automatic logic expected_parity(input logic [1:0] sel, input logic data_xor);
        logic p;
        case (sel)
            PAR_EVEN:   p = data_xor;
            PAR_ODD:    p = ~data_xor;
            PAR_STICK0: p = 1'b0;
            default:    p = 1'b1;
        endcase
        return p;
    endfunction

endpackage

// File: rtl/uart_baud_tick.sv
// Baud divisor and oversample counter; restart aligns both to the start edge.
module uart_baud_tick #(
    parameter int OVERSAMPLE = 16,
    parameter int DIV_WIDTH  = 16
) (
    input  logic                          clk_i,
    input  logic                          rst_n_i,
    input  logic                          i_run,
    input  logic                          i_restart,
    input  logic [DIV_WIDTH-1:0]          i_div,
    output logic                          o_tick,
    output logic [$clog2(OVERSAMPLE)-1:0] o_samp
);

    localparam int SW = $clog2(OVERSAMPLE);
    localparam logic [SW-1:0] SAMP_LAST = SW'(OVERSAMPLE - 1);

    logic [DIV_WIDTH-1:0] r_div_cnt;
    logic [SW-1:0]        r_samp_cnt;
    logic [DIV_WIDTH-1:0] w_reload;

    // A divisor of 0 behaves like 1: reload to 0, tick every clock.
    assign w_reload = (i_div == '0) ? '0 : i_div - DIV_WIDTH'(1);
    assign o_tick   = i_run && !i_restart && (r_div_cnt == '0);
    assign o_samp   = r_samp_cnt;

    // NOTE: state registers use <= so every flop samples pre-edge values.
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            r_div_cnt  <= '0;
            r_samp_cnt <= '0;
        end else if (!i_run || i_restart) begin
            r_div_cnt  <= '0;
            r_samp_cnt <= '0;
        end else if (r_div_cnt == '0) begin
            r_div_cnt  <= w_reload;
            r_samp_cnt <= (r_samp_cnt == SAMP_LAST) ? '0 : r_samp_cnt + SW'(1);
        end else begin
            r_div_cnt <= r_div_cnt - DIV_WIDTH'(1);
        end
    end

endmodule

// File: rtl/uart_rx_os.sv
// Oversampling UART receiver: majority vote, 5..9 data bits, parity, break, overrun, timeout.
module uart_rx_os
    import uart_pkg::*;
#(
    parameter int OVERSAMPLE    = 16,
    parameter int DIV_WIDTH     = 16,
    parameter int MAX_DATA_BITS = 9,
    parameter int TIMEOUT_CHARS = 4
) (
    input  logic                     clk_i,
    input  logic                     rst_n_i,
    input  logic                     rx_i,
    input  logic                     cfg_en_i,
    input  logic [DIV_WIDTH-1:0]     cfg_div_i,
    input  logic [2:0]               cfg_bits_i,
    input  logic                     cfg_parity_en_i,
    input  logic [1:0]               cfg_parity_sel_i,
    output logic [MAX_DATA_BITS-1:0] rx_data_o,
    output logic                     rx_valid_o,
    input  logic                     rx_ready_i,
    output logic                     pe_o,
    output logic                     fe_o,
    output logic                     brk_o,
    output logic                     ovr_o,
    input  logic                     err_clr_i,
    output logic                     timeout_o,
    output logic                     busy_o
);

    localparam int SW       = $clog2(OVERSAMPLE);
    localparam int TO_TICKS = TIMEOUT_CHARS * BITS_PER_CHAR * OVERSAMPLE;
    localparam int TW       = $clog2(TO_TICKS);
    localparam logic [SW-1:0] SAMP_A  = SW'(OVERSAMPLE / 2 - 1);
    localparam logic [SW-1:0] SAMP_B  = SW'(OVERSAMPLE / 2);
    localparam logic [SW-1:0] SAMP_C  = SW'(OVERSAMPLE / 2 + 1);
    localparam logic [TW-1:0] TO_LAST = TW'(TO_TICKS - 1);

    logic r_sync1, r_sync2, r_rx_last;
    logic r_s_a, r_s_b;
    rx_state_t r_state, w_state_nxt;

    logic          w_tick;
    logic [SW-1:0] w_samp;
    logic w_fall, w_start, w_decide, w_vote;
    logic w_stop_done, w_break, w_complete, w_hs, w_accept, w_drop, w_last_bit, w_exp_par;

    logic [3:0]               r_nbits;
    logic                     r_par_en;
    logic [1:0]               r_par_sel;
    logic [MAX_DATA_BITS-1:0] r_shift;
    logic [3:0]               r_bit_cnt;
    logic                     r_pe_cur, r_par_bit;

    logic [MAX_DATA_BITS-1:0] r_data;
    logic r_valid, r_pe, r_fe, r_brk, r_ovr, r_timeout;
    logic          r_to_armed;
    logic [TW-1:0] r_to_cnt;

    uart_baud_tick #(
        .OVERSAMPLE(OVERSAMPLE),
        .DIV_WIDTH (DIV_WIDTH)
    ) u_tick (
        .clk_i    (clk_i),
        .rst_n_i  (rst_n_i),
        .i_run    (cfg_en_i),
        .i_restart(w_start),
        .i_div    (cfg_div_i),
        .o_tick   (w_tick),
        .o_samp   (w_samp)
    );

    assign w_fall      = r_rx_last & ~r_sync2;
    assign w_start     = cfg_en_i && (r_state == S_IDLE) && w_fall;
    assign w_decide    = w_tick && (w_samp == SAMP_C);
    assign w_vote      = (r_s_a & r_s_b) | (r_s_a & r_sync2) | (r_s_b & r_sync2);
    assign w_last_bit  = (r_bit_cnt == (r_nbits - 4'd1));
    assign w_exp_par   = expected_parity(r_par_sel, ^r_shift);
    assign w_stop_done = cfg_en_i && (r_state == S_STOP) && w_decide;
    assign w_break     = w_stop_done && !w_vote && (r_shift == '0) && (!r_par_en || !r_par_bit);
    assign w_complete  = w_stop_done && !w_break;
    assign w_hs        = r_valid && rx_ready_i;
    assign w_accept    = w_complete && (!r_valid || w_hs);
    assign w_drop      = w_complete && !w_accept;

    // Synchroniser flops idle high so reset release never looks like a start edge.
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            r_sync1   <= 1'b1;
            r_sync2   <= 1'b1;
            r_rx_last <= 1'b1;
            r_s_a     <= 1'b1;
            r_s_b     <= 1'b1;
        end else begin
            r_sync1   <= rx_i;
            r_sync2   <= r_sync1;
            r_rx_last <= r_sync2;
            if (w_tick && (w_samp == SAMP_A)) r_s_a <= r_sync2;
            if (w_tick && (w_samp == SAMP_B)) r_s_b <= r_sync2;
        end
    end

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) r_state <= S_IDLE;
        else          r_state <= w_state_nxt;
    end

    // NOTE: next state defaults to the current state so no path infers a latch.
    always_comb begin
        w_state_nxt = r_state;
        if (!cfg_en_i) begin
            w_state_nxt = S_IDLE;
        end else begin
            case (r_state)
                S_IDLE:   if (w_fall)   w_state_nxt = S_START;
                S_START:  if (w_decide) w_state_nxt = w_vote ? S_IDLE : S_DATA;
                S_DATA:   if (w_decide && w_last_bit) w_state_nxt = r_par_en ? S_PARITY : S_STOP;
                S_PARITY: if (w_decide) w_state_nxt = S_STOP;
                S_STOP:   if (w_decide) w_state_nxt = w_break ? S_BREAK : S_IDLE;
                S_BREAK:  if (r_sync2)  w_state_nxt = S_IDLE;
                default:  w_state_nxt = S_IDLE;
            endcase
        end
    end

    // Frame datapath: configuration is frozen at the start edge for the whole character.
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            r_nbits   <= '0;
            r_par_en  <= 1'b0;
            r_par_sel <= '0;
            r_shift   <= '0;
            r_bit_cnt <= '0;
            r_pe_cur  <= 1'b0;
            r_par_bit <= 1'b0;
        end else if (w_start) begin
            r_nbits   <= eff_data_bits(cfg_bits_i, MAX_DATA_BITS);
            r_par_en  <= cfg_parity_en_i;
            r_par_sel <= cfg_parity_sel_i;
            r_shift   <= '0;
            r_bit_cnt <= '0;
            r_pe_cur  <= 1'b0;
            r_par_bit <= 1'b0;
        end else if (w_decide && cfg_en_i) begin
            case (r_state)
                S_DATA: begin
                    r_shift[r_bit_cnt] <= w_vote;
                    r_bit_cnt          <= r_bit_cnt + 4'd1;
                end
                S_PARITY: begin
                    r_par_bit <= w_vote;
                    r_pe_cur  <= (w_vote != w_exp_par);
                end
                default: ;
            endcase
        end
    end

    // Delivery register and sticky flags; a new set wins over a same-cycle clear.
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            r_data  <= '0;
            r_valid <= 1'b0;
            r_pe    <= 1'b0;
            r_fe    <= 1'b0;
            r_brk   <= 1'b0;
            r_ovr   <= 1'b0;
        end else begin
            if (w_accept) begin
                r_data  <= r_shift;
                r_pe    <= r_pe_cur;
                r_fe    <= ~w_vote;
                r_valid <= 1'b1;
            end else if (w_hs) begin
                r_valid <= 1'b0;
            end
            r_brk <= w_break | (r_brk & ~err_clr_i);
            r_ovr <= w_drop  | (r_ovr & ~err_clr_i);
        end
    end

    // Character timeout counts ticks spent idle after a completed character.
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            r_timeout  <= 1'b0;
            r_to_armed <= 1'b0;
            r_to_cnt   <= '0;
        end else begin
            r_timeout <= 1'b0;
            if (!cfg_en_i) begin
                r_to_armed <= 1'b0;
                r_to_cnt   <= '0;
            end else if (w_start) begin
                r_to_cnt <= '0;
            end else if (w_complete) begin
                r_to_armed <= 1'b1;
                r_to_cnt   <= '0;
            end else if (r_to_armed && (r_state == S_IDLE) && w_tick) begin
                if (r_to_cnt == TO_LAST) begin
                    r_timeout  <= 1'b1;
                    r_to_armed <= 1'b0;
                    r_to_cnt   <= '0;
                end else begin
                    r_to_cnt <= r_to_cnt + TW'(1);
                end
            end
        end
    end

    assign rx_data_o  = r_data;
    assign rx_valid_o = r_valid;
    assign pe_o       = r_pe;
    assign fe_o       = r_fe;
    assign brk_o      = r_brk;
    assign ovr_o      = r_ovr;
    assign timeout_o  = r_timeout;
    assign busy_o     = (r_state != S_IDLE);

endmodule
